// File: rtl/rhs_resize_pipe_if.sv
// Streaming bundle for rhs_resize_pipe: input beat channel and output beat channel.
// slave = the resize pipe, master = the producer/consumer pair around it.
interface rhs_resize_pipe_if #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 3,
  parameter int NCH   = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*IN_W-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*OUT_W-1:0] out_data;
  logic [NCH-1:0]       out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/rhs_resize_pipe.sv
// Two-stage multi-channel resize: stage 1 adds INC at IN_W+1 bits, stage 2 truncates or
// saturates to OUT_W. Optional overflow beat counter under RHS_RESIZE_OVF_CNT_EN.
module rhs_resize_pipe #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 3,
  parameter int NCH   = 2,
  parameter int INC   = 1,
  parameter int SAT   = 0
`ifdef RHS_RESIZE_OVF_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  rhs_resize_pipe_if.slave bus,
  input  logic             ovf_clr,
  output logic [NCH-1:0]   ovf_sticky
`ifdef RHS_RESIZE_OVF_CNT_EN
  , output logic [CNT_W-1:0] ovf_cnt
`endif
);

  localparam int SUM_W = IN_W + 1;

  logic             s1_valid_reg;
  logic [SUM_W-1:0] s1_sum_reg  [NCH];
  logic [SUM_W-1:0] s1_sum_next [NCH];
  logic             out_valid_reg;
  logic [OUT_W-1:0] out_data_reg [NCH];
  logic [OUT_W-1:0] cast_next    [NCH];
  logic [NCH-1:0]   out_ovf_reg;
  logic [NCH-1:0]   ovf_next;
  logic [NCH-1:0]   sticky_reg;
  logic [NCH-1:0]   sticky_next;
  logic             s2_load;
  logic             s1_load;
  logic             out_hs;

  assign s2_load       = !out_valid_reg || bus.out_ready;
  assign s1_load       = s2_load || !s1_valid_reg;
  assign out_hs        = out_valid_reg && bus.out_ready;
  assign bus.in_ready  = s1_load;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_ovf   = out_ovf_reg;
  assign ovf_sticky    = sticky_reg;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign s1_sum_next[gi] = SUM_W'(bus.in_data[gi*IN_W +: IN_W]) + SUM_W'(INC);

      if (OUT_W >= SUM_W) begin : g_wide
        assign cast_next[gi] = OUT_W'(s1_sum_reg[gi]);
        assign ovf_next[gi]  = 1'b0;
      end else begin : g_narrow
        // any set bit above the output range means the sum does not fit
        assign ovf_next[gi]  = |s1_sum_reg[gi][SUM_W-1:OUT_W];
        assign cast_next[gi] = (SAT != 0 && ovf_next[gi]) ? {OUT_W{1'b1}}
                                                          : s1_sum_reg[gi][OUT_W-1:0];
      end

      assign bus.out_data[gi*OUT_W +: OUT_W] = out_data_reg[gi];
      // a set on the handshake beats a simultaneous clear
      assign sticky_next[gi] = (out_hs && out_ovf_reg[gi]) || (sticky_reg[gi] && !ovf_clr);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      for (int c = 0; c < NCH; c++) s1_sum_reg[c] <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        for (int c = 0; c < NCH; c++) s1_sum_reg[c] <= s1_sum_next[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_ovf_reg   <= '0;
      for (int c = 0; c < NCH; c++) out_data_reg[c] <= '0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_ovf_reg <= ovf_next;
        for (int c = 0; c < NCH; c++) out_data_reg[c] <= cast_next[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_reg <= '0;
    else        sticky_reg <= sticky_next;
  end

`ifdef RHS_RESIZE_OVF_CNT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (out_hs && (|out_ovf_reg)) begin
      if (ovf_clr)               cnt_next = CNT_W'(1);
      else if (cnt_reg != '1)    cnt_next = cnt_reg + CNT_W'(1);
    end else if (ovf_clr) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign ovf_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_rhs_resize_pipe.sv
// Directed bench: three pipes (truncate / saturate / wide output) driven by one stimulus.
// Counter checks are compiled in only with RHS_RESIZE_OVF_CNT_EN.
module tb_rhs_resize_pipe;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_data;
  logic        out_ready;
  logic        ovf_clr;
  logic [1:0]  sticky_t, sticky_s, sticky_w;
`ifdef RHS_RESIZE_OVF_CNT_EN
  logic [7:0]  cnt_t;
  logic [1:0]  cnt_s;
  logic [7:0]  cnt_w;
`endif
  int checks;
  int errors;

  rhs_resize_pipe_if #(.IN_W(6), .OUT_W(3), .NCH(2)) if_t ();
  rhs_resize_pipe_if #(.IN_W(6), .OUT_W(3), .NCH(2)) if_s ();
  rhs_resize_pipe_if #(.IN_W(6), .OUT_W(8), .NCH(2)) if_w ();

  assign if_t.in_valid = in_valid;  assign if_t.in_data = in_data;  assign if_t.out_ready = out_ready;
  assign if_s.in_valid = in_valid;  assign if_s.in_data = in_data;  assign if_s.out_ready = out_ready;
  assign if_w.in_valid = in_valid;  assign if_w.in_data = in_data;  assign if_w.out_ready = out_ready;

  rhs_resize_pipe #(.IN_W(6), .OUT_W(3), .NCH(2), .INC(1), .SAT(0)
`ifdef RHS_RESIZE_OVF_CNT_EN
    , .CNT_W(8)
`endif
  ) dut_t (
    .clk(clk), .rst_n(rst_n), .bus(if_t.slave), .ovf_clr(ovf_clr), .ovf_sticky(sticky_t)
`ifdef RHS_RESIZE_OVF_CNT_EN
    , .ovf_cnt(cnt_t)
`endif
  );

  rhs_resize_pipe #(.IN_W(6), .OUT_W(3), .NCH(2), .INC(1), .SAT(1)
`ifdef RHS_RESIZE_OVF_CNT_EN
    , .CNT_W(2)
`endif
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(if_s.slave), .ovf_clr(ovf_clr), .ovf_sticky(sticky_s)
`ifdef RHS_RESIZE_OVF_CNT_EN
    , .ovf_cnt(cnt_s)
`endif
  );

  rhs_resize_pipe #(.IN_W(6), .OUT_W(8), .NCH(2), .INC(1), .SAT(0)
`ifdef RHS_RESIZE_OVF_CNT_EN
    , .CNT_W(8)
`endif
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(if_w.slave), .ovf_clr(ovf_clr), .ovf_sticky(sticky_w)
`ifdef RHS_RESIZE_OVF_CNT_EN
    , .ovf_cnt(cnt_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // one beat in, then one cycle for it to reach the output register
  task automatic send(input logic [11:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;  errors = 0;
    rst_n = 1'b0;  in_valid = 1'b0;  in_data = '0;  out_ready = 1'b1;  ovf_clr = 1'b0;
    #1;
    chk("rst_out_valid", 32'(if_t.out_valid), 32'h0);
    chk("rst_out_data",  32'(if_t.out_data),  32'h0);
    chk("rst_out_ovf",   32'(if_t.out_ovf),   32'h0);
    chk("rst_sticky",    32'(sticky_t),       32'h0);
`ifdef RHS_RESIZE_OVF_CNT_EN
    chk("rst_cnt",       32'(cnt_t),          32'h0);
`endif
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // basic add, no overflow
    in_valid = 1'b1;  in_data = {6'd2, 6'd6};
    #1 chk("t1_in_ready", 32'(if_t.in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("t1_lat_not1", 32'(if_t.out_valid), 32'h0);
    tick();
    chk("t1_valid",  32'(if_t.out_valid), 32'h1);
    chk("t1_data_t", 32'(if_t.out_data),  32'h1F);
    chk("t1_ovf_t",  32'(if_t.out_ovf),   32'h0);
    chk("t1_data_w", 32'(if_w.out_data),  32'h0307);
    tick();
    chk("t1_drained", 32'(if_t.out_valid), 32'h0);
    chk("t1_sticky",  32'(sticky_t),       32'h0);

    // ch0 overflow: 7+1=8
    send({6'd0, 6'd7});
    chk("t2_data_t", 32'(if_t.out_data), 32'h08);
    chk("t2_ovf_t",  32'(if_t.out_ovf),  32'h1);
    chk("t2_data_s", 32'(if_s.out_data), 32'h0F);
    chk("t2_ovf_s",  32'(if_s.out_ovf),  32'h1);
    chk("t2_data_w", 32'(if_w.out_data), 32'h0108);
    chk("t2_ovf_w",  32'(if_w.out_ovf),  32'h0);
    tick();
    chk("t2_sticky_t", 32'(sticky_t), 32'h1);
    chk("t2_sticky_s", 32'(sticky_s), 32'h1);
    chk("t2_sticky_w", 32'(sticky_w), 32'h0);
`ifdef RHS_RESIZE_OVF_CNT_EN
    chk("t2_cnt_t", 32'(cnt_t), 32'h1);
    chk("t2_cnt_w", 32'(cnt_w), 32'h0);
`endif

    // ch1 overflow: 63+1=64
    send({6'd63, 6'd0});
    chk("t3_data_t", 32'(if_t.out_data), 32'h01);
    chk("t3_ovf_t",  32'(if_t.out_ovf),  32'h2);
    chk("t3_data_s", 32'(if_s.out_data), 32'h39);
    chk("t3_ovf_s",  32'(if_s.out_ovf),  32'h2);
    chk("t3_data_w", 32'(if_w.out_data), 32'h4001);
    chk("t3_ovf_w",  32'(if_w.out_ovf),  32'h0);
    tick();
    chk("t3_sticky_t", 32'(sticky_t), 32'h3);
`ifdef RHS_RESIZE_OVF_CNT_EN
    chk("t3_cnt_s", 32'(cnt_s), 32'h2);
`endif

    // clear coinciding with an overflowing handshake on ch0 only
    send({6'd0, 6'd7});
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t5_setwins_t", 32'(sticky_t), 32'h1);
    chk("t5_setwins_s", 32'(sticky_s), 32'h1);
`ifdef RHS_RESIZE_OVF_CNT_EN
    chk("t5_cnt_clrinc", 32'(cnt_t), 32'h1);
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t5_clr_sticky", 32'(sticky_t), 32'h0);
`ifdef RHS_RESIZE_OVF_CNT_EN
    chk("t5_clr_cnt",    32'(cnt_t),    32'h0);
`endif

    // four back-to-back overflowing beats at full rate
    in_valid = 1'b1;  in_data = {6'd63, 6'd7};
    for (int i = 0; i < 4; i++) begin
      #1 chk("t5_stream_ready", 32'(if_t.in_ready), 32'h1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("t5_stream_drained", 32'(if_t.out_valid), 32'h0);
    chk("t5_stream_sticky",  32'(sticky_t),       32'h3);
`ifdef RHS_RESIZE_OVF_CNT_EN
    chk("t5_cnt_t4",  32'(cnt_t), 32'h4);
    chk("t5_cnt_sat", 32'(cnt_s), 32'h3);
`endif

    // stall: two beats fill the pipe, then backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;  in_data = {6'd0, 6'd1};
    #1 chk("t4_rdy_b1", 32'(if_t.in_ready), 32'h1);
    tick();
    in_data = {6'd0, 6'd2};
    #1 chk("t4_rdy_b2", 32'(if_t.in_ready), 32'h1);
    tick();
    in_data = {6'd0, 6'd3};
    #1 chk("t4_full_rdy", 32'(if_t.in_ready), 32'h0);
    chk("t4_full_valid", 32'(if_t.out_valid), 32'h1);
    chk("t4_full_data",  32'(if_t.out_data),  32'h0A);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("t4_stall_rdy",  32'(if_t.in_ready), 32'h0);
      chk("t4_stall_data", 32'(if_t.out_data), 32'h0A);
    end
    out_ready = 1'b1;
    #1 chk("t4_release_rdy", 32'(if_t.in_ready), 32'h1);
    chk("t4_out2", 32'(if_t.out_data), 32'h0A);
    tick();
    in_data = {6'd0, 6'd4};
    chk("t4_out3", 32'(if_t.out_data), 32'h0B);
    tick();
    in_valid = 1'b0;
    chk("t4_out4", 32'(if_t.out_data), 32'h0C);
    tick();
    chk("t4_out5",   32'(if_t.out_data),  32'h0D);
    chk("t4_out5_v", 32'(if_t.out_valid), 32'h1);
    tick();
    chk("t4_empty", 32'(if_t.out_valid), 32'h0);

    // asynchronous reset while a beat is held at the output
    out_ready = 1'b0;
    send({6'd1, 6'd1});
    chk("t6_held_valid", 32'(if_t.out_valid), 32'h1);
    chk("t6_held_data",  32'(if_t.out_data),  32'h12);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",  32'(if_t.out_valid), 32'h0);
    chk("t6_rst_data",   32'(if_t.out_data),  32'h0);
    chk("t6_rst_sticky", 32'(sticky_t),       32'h0);
    chk("t6_rst_ready",  32'(if_t.in_ready),  32'h1);
`ifdef RHS_RESIZE_OVF_CNT_EN
    chk("t6_rst_cnt",    32'(cnt_t),          32'h0);
`endif
    tick();
    rst_n = 1'b1;  out_ready = 1'b1;
    in_valid = 1'b1;  in_data = {6'd4, 6'd3};
    tick();
    in_valid = 1'b0;
    chk("t6_post_lat1", 32'(if_t.out_valid), 32'h0);
    tick();
    chk("t6_post_valid", 32'(if_t.out_valid), 32'h1);
    chk("t6_post_data",  32'(if_t.out_data),  32'h2C);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
